// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit-over-16-bit SRAM access sequencer:
// FSM state encoding, default base address and the byte-to-word mapping.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte address that lands on SRAM word 0.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // 32-bit word index inside the SRAM; truncation makes the window wrap every 512 KB.
  function automatic logic [16:0] word_index(input logic [31:0] address,
                                             input logic [31:0] base);
    return 17'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit half-accesses on the
// asynchronous SRAM (low half first) and holds ready low while busy.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  // Final count value of a half-access phase.
  localparam logic [2:0] LAST_COUNT = 3'(WAIT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  count_reg, count_next;
  logic        op_write_reg, op_write_next;
  logic        req;
  logic        last;
  logic        half;
  logic        active;
  logic        dq_drive;
  logic [15:0] dq_out;

  assign req    = rdEn | wrEn;
  assign last   = (count_reg == LAST_COUNT);
  assign half   = (state_reg == HIGH);
  assign active = (state_reg == LOW) || (state_reg == HIGH);

  // Full 16-bit accesses only; the chip is permanently selected.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_ADDR = {word_index(address, BASE_ADDR), half};
  assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;

  // State, phase counter and latched operation; reset aborts any access at once.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= 3'd0;
      op_write_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      op_write_reg <= op_write_next;
    end
  end

  // Next-state sequencing plus the SRAM strobes, bus drive and ready.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_write_next = op_write_reg;
    ready         = 1'b0;
    SRAM_WE_N     = 1'b1;
    SRAM_OE_N     = 1'b1;
    dq_drive      = 1'b0;
    dq_out        = writeData[15:0];

    case (state_reg)
      IDLE: begin
        ready = !req;
        if (req) begin
          // Write has priority when both requests are raised.
          op_write_next = wrEn;
          state_next    = LOW;
          count_next    = 3'd0;
        end
      end
      LOW: begin
        if (last) begin
          state_next = HIGH;
          count_next = 3'd0;
        end else begin
          count_next = count_reg + 3'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_next = DONE;
          count_next = 3'd0;
        end else begin
          count_next = count_reg + 3'd1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
        count_next = 3'd0;
      end
      default: state_next = IDLE;
    endcase

    if (active) begin
      if (op_write_reg) begin
        dq_drive = 1'b1;
        dq_out   = half ? writeData[31:16] : writeData[15:0];
        // Release WE_N on the final cycle of a phase so address/data are held
        // past the strobe; a single-cycle phase keeps it low throughout.
        SRAM_WE_N = (WAIT_CYCLES != 1) && last;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  // Capture each read half at the end of its phase; writes leave readData alone.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      readData <= 32'd0;
    end else if (active && !op_write_reg && last) begin
      if (half) begin
        readData[31:16] <= SRAM_DQ;
      end else begin
        readData[15:0] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES 1 and 3) each on its own
// behavioural SRAM, compared every cycle against a timeline-based reference.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en, wr_en, ready, we_n, oe_n;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [17:0] sram_addr [2];
  logic [15:0] dq_mon [2];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      wire  [15:0] dq;
      logic        ub_n, lb_n, ce_n;
      logic [15:0] mem [262144];

      sram_controller #(
        .BASE_ADDR  (32'd1024),
        .WAIT_CYCLES(gi == 0 ? 1 : 3)
      ) dut (
        .clock    (clk),
        .rst      (rst),
        .rdEn     (rd_en[gi]),
        .wrEn     (wr_en[gi]),
        .address  (addr[gi]),
        .writeData(wdata[gi]),
        .readData (rdata[gi]),
        .ready    (ready[gi]),
        .SRAM_DQ  (dq),
        .SRAM_ADDR(sram_addr[gi]),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n[gi]),
        .SRAM_WE_N(we_n[gi])
      );

      // Asynchronous SRAM: drives stored data while OE_N low and WE_N high.
      assign dq = (!oe_n[gi] && we_n[gi]) ? mem[sram_addr[gi]] : 16'bz;
      assign dq_mon[gi] = dq;

      initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
      end

      always @(posedge clk) begin
        if (!we_n[gi]) mem[sram_addr[gi]] = dq;
      end
    end
  endgenerate

  // ---------------- reference model ----------------
  // pos = cycle number inside the current access: 0 idle, 1..W low half,
  // W+1..2W high half, 2W+1 the completing cycle.
  int          pos [2] = '{0, 0};
  bit          op_wr [2];
  logic [31:0] rd_model [2] = '{32'd0, 32'd0};
  logic [31:0] exp_mem [int];
  bit          chk_en = 1'b0;
  logic [31:0] ew;

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (k << 20) | int'(off[18:2]);
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] a);
    if (exp_mem.exists(key(k, a))) return exp_mem[key(k, a)];
    return 32'd0;
  endfunction

  task automatic check(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  // Undriven bus reads as Z (4-state) or 0 (2-state); anything else is a stray driver.
  task automatic check_quiet(input int k, input string name, input logic [15:0] v);
    checks++;
    if (v !== 16'h0000 && v !== 16'bz) begin
      errors++;
      $display("FAIL %s dut%0d: bus shows %h, expected undriven", name, k, v);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        pos[k]      = 0;
        rd_model[k] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pos[k] == 0) begin
          if (rd_en[k] | wr_en[k]) begin
            op_wr[k] = wr_en[k];
            pos[k]   = 1;
            if (wr_en[k]) exp_mem[key(k, addr[k])] = wdata[k];
          end
        end else begin
          ew = exp_word(k, addr[k]);
          if (!op_wr[k] && pos[k] == wc(k))     rd_model[k][15:0]  = ew[15:0];
          if (!op_wr[k] && pos[k] == 2 * wc(k)) rd_model[k][31:16] = ew[31:16];
          pos[k] = (pos[k] == 2 * wc(k) + 1) ? 0 : pos[k] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      for (int k = 0; k < 2; k++) begin
        int  w;
        bit  act_ph, hi;
        int  pin;
        logic [31:0] off;
        w      = wc(k);
        act_ph = (pos[k] >= 1) && (pos[k] <= 2 * w);
        hi     = pos[k] > w;
        pin    = hi ? pos[k] - w : pos[k];
        off    = addr[k] - 32'd1024;
        check(k, "ready", ready[k],
              ((pos[k] == 0 && !(rd_en[k] | wr_en[k])) || pos[k] == 2 * w + 1) ? 1 : 0);
        check(k, "we_n", we_n[k],
              (act_ph && op_wr[k] && (w == 1 || pin != w)) ? 0 : 1);
        check(k, "oe_n", oe_n[k], (act_ph && !op_wr[k]) ? 0 : 1);
        check(k, "readData", rdata[k], rd_model[k]);
        if (act_ph) check(k, "sram_addr", sram_addr[k], {off[18:2], hi});
        if (act_ph && op_wr[k])
          check(k, "dq_write", dq_mon[k], hi ? wdata[k][31:16] : wdata[k][15:0]);
        else if (!act_ph)
          check_quiet(k, "dq_idle", dq_mon[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int lows, we_lows, oe_lows;

  task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d);
    bit done;
    @(posedge clk);
    #1;
    rd_en[k] = rd;
    wr_en[k] = wr;
    addr[k]  = a;
    wdata[k] = d;
    lows = 0; we_lows = 0; oe_lows = 0; done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!we_n[k]) we_lows++;
      if (!oe_n[k]) oe_lows++;
      if (ready[k]) done = 1;
      else lows++;
    end
    check(k, "handshake_done", done, 1);
    @(posedge clk);
    #1;
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, run;
    int runs [2];
    int k, op;
    logic [31:0] a;

    rst = 1'b0;
    rd_en = 2'b00;
    wr_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'd1024;
      wdata[i] = 32'd0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 2; i++) begin
      check(i, "rst_ready", ready[i], 1);
      check(i, "rst_we_n", we_n[i], 1);
      check(i, "rst_oe_n", oe_n[i], 1);
      check(i, "rst_readData", rdata[i], 32'd0);
      check_quiet(i, "rst_dq", dq_mon[i]);
    end
    check(0, "ce_n", g_dut[0].ce_n, 0);
    check(1, "ub_lb_n", {g_dut[1].ub_n, g_dut[1].lb_n}, 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Write then read, WAIT_CYCLES = 1. lows counts the request cycle too.
    access(0, 0, 1, 32'd1024, 32'hDEADBEEF);
    check(0, "w1_stall_after_req", lows - 1, 2);
    check(0, "w1_we_low_cycles", we_lows, 2);
    check(0, "mem0", g_dut[0].mem[0], 16'hBEEF);
    check(0, "mem1", g_dut[0].mem[1], 16'hDEAD);
    access(0, 1, 0, 32'd1024, 32'd0);
    check(0, "r1_stall_after_req", lows - 1, 2);
    check(0, "r1_data", rdata[0], 32'hDEADBEEF);

    // Address map and wrap
    access(0, 0, 1, 32'd1028, 32'h12345678);
    check(0, "mem2", g_dut[0].mem[2], 16'h5678);
    check(0, "mem3", g_dut[0].mem[3], 16'h1234);
    access(0, 0, 1, 32'd1024 + 32'h80000, 32'h0BADF00D);
    check(0, "wrap_mem0", g_dut[0].mem[0], 16'hF00D);
    check(0, "wrap_mem1", g_dut[0].mem[1], 16'h0BAD);
    access(0, 1, 0, 32'd1028, 32'd0);
    check(0, "r2_data", rdata[0], 32'h12345678);

    // Simultaneous read+write: write wins
    access(0, 1, 1, 32'd1036, 32'hA5A5A5A5);
    check(0, "both_readData_kept", rdata[0], 32'h12345678);
    check(0, "both_oe_low_cycles", oe_lows, 0);
    check(0, "both_mem6", g_dut[0].mem[6], 16'hA5A5);
    check(0, "both_mem7", g_dut[0].mem[7], 16'hA5A5);

    // WAIT_CYCLES = 3 latency; word of 1100 is 19 -> half-words 38/39
    access(1, 0, 1, 32'd1100, 32'hCAFEF00D);
    check(1, "w3_stall_after_req", lows - 1, 6);
    check(1, "w3_we_low_cycles", we_lows, 4);
    check(1, "w3_mem38", g_dut[1].mem[38], 16'hF00D);
    check(1, "w3_mem39", g_dut[1].mem[39], 16'hCAFE);
    access(1, 1, 0, 32'd1100, 32'd0);
    check(1, "r3_stall_after_req", lows - 1, 6);
    check(1, "r3_data", rdata[1], 32'hCAFEF00D);

    // Back-to-back: read held across two accesses
    @(posedge clk);
    #1;
    rd_en[1] = 1'b1;
    addr[1]  = 32'd1100;
    pulses = 0; run = 0; runs[0] = 0; runs[1] = 0;
    for (int i = 0; i < 100 && pulses < 2; i++) begin
      @(negedge clk);
      if (ready[1]) begin
        runs[pulses] = run;
        run = 0;
        pulses++;
      end else begin
        run++;
      end
    end
    check(1, "b2b_pulses", pulses, 2);
    check(1, "b2b_first_gap", runs[0], 7);
    check(1, "b2b_second_gap", runs[1], 7);
    @(posedge clk);
    #1;
    rd_en[1] = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      a  = 32'd1024 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) == 1 ? 32'h80000 : 32'h0);
      access(k, op != 1, op != 0, a, $urandom);
    end

    // Known readData before the reset test
    access(0, 0, 1, 32'd1024, 32'h600DCAFE);
    access(0, 1, 0, 32'd1024, 32'd0);
    check(0, "pre_rst_data", rdata[0], 32'h600DCAFE);

    // Reset in the middle of a write's HIGH half
    @(posedge clk);
    #1;
    wr_en[0] = 1'b1;
    addr[0]  = 32'd1040;
    wdata[0] = 32'h11112222;
    @(posedge clk);
    @(posedge clk);
    #5;
    check(0, "high_we_n", we_n[0], 0);
    check(0, "high_dq", dq_mon[0], 16'h1111);
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check(0, "mid_rst_we_n", we_n[0], 1);
    check(0, "mid_rst_oe_n", oe_n[0], 1);
    check_quiet(0, "mid_rst_dq", dq_mon[0]);
    check(0, "mid_rst_readData", rdata[0], 32'd0);
    check(0, "mid_rst_ready_req_held", ready[0], 0);
    wr_en[0] = 1'b0;
    #1;
    check(0, "mid_rst_ready", ready[0], 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check(0, "post_rst_ready", ready[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
